// File: rtl/banco_pkg.sv
// Shared definitions for the parametrised register bank: FSM state encoding.
package banco_pkg;

    typedef enum logic {
        ESTADO_PRONTO   = 1'b0,
        ESTADO_LIMPANDO = 1'b1
    } estado_t;

endpackage

// File: rtl/memoria_2r1w.sv
// Plain storage array, one write port and two registered read ports (read-before-write).
// No reset and no bypass, so it can map onto RAM.
module memoria_2r1w #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  escreve,
    input  logic [ADDR_WIDTH-1:0] endereco_escrita,
    input  logic [DATA_WIDTH-1:0] dado_escrita,
    input  logic [ADDR_WIDTH-1:0] endereco_a,
    input  logic [ADDR_WIDTH-1:0] endereco_b,
    output logic [DATA_WIDTH-1:0] dado_a,
    output logic [DATA_WIDTH-1:0] dado_b
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (escreve) begin
            mem[endereco_escrita] <= dado_escrita;
        end
        dado_a <= mem[endereco_a];
        dado_b <= mem[endereco_b];
    end

endmodule

// File: rtl/banco_registradores_param.sv
// 2-read/1-write register file with clear sweep, optional bypass, optional zero R0 and pending bits.
// Reads are registered (1 cycle); outputs stay 0 unless the bank was ready both before and after the sampling edge.
module banco_registradores_param
    import banco_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_R0    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  limpar,
    output logic                  pronto,
    input  logic                  habilita_escrita,
    input  logic [ADDR_WIDTH-1:0] endereco_escrita,
    input  logic [DATA_WIDTH-1:0] dado_escrita,
    input  logic                  marca_pendente,
    input  logic [ADDR_WIDTH-1:0] endereco_pendente,
    input  logic [ADDR_WIDTH-1:0] endereco_leitura_A,
    input  logic [ADDR_WIDTH-1:0] endereco_leitura_B,
    output logic [DATA_WIDTH-1:0] dado_leitura_A,
    output logic [DATA_WIDTH-1:0] dado_leitura_B,
    output logic                  pendente_A,
    output logic                  pendente_B
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ULTIMO = ADDR_WIDTH'(DEPTH - 1);

    function automatic logic eh_zero(input logic [ADDR_WIDTH-1:0] endereco);
        return (ZERO_R0 != 0) && (endereco == '0);
    endfunction

    estado_t               estado;
    logic [ADDR_WIDTH-1:0] contador;
    logic [DEPTH-1:0]      pendentes;
    logic [DEPTH-1:0]      pendentes_prox;

    logic                  usuario_ativo;
    logic                  escrita_ok;
    logic                  marca_ok;
    logic                  mem_escreve;
    logic [ADDR_WIDTH-1:0] mem_endereco;
    logic [DATA_WIDTH-1:0] mem_dado;
    logic [DATA_WIDTH-1:0] mem_a;
    logic [DATA_WIDTH-1:0] mem_b;

    logic                  saida_ok;
    logic                  zero_a;
    logic                  zero_b;
    logic                  acerto_a;
    logic                  acerto_b;
    logic [DATA_WIDTH-1:0] dado_bypass;
    logic                  pend_a;
    logic                  pend_b;

    // User traffic only counts when the bank stays ready across this edge.
    assign usuario_ativo = (estado == ESTADO_PRONTO) && !limpar && !reset;
    assign escrita_ok    = usuario_ativo && habilita_escrita && !eh_zero(endereco_escrita);
    assign marca_ok      = usuario_ativo && marca_pendente && !eh_zero(endereco_pendente);

    assign mem_escreve  = !reset && ((estado == ESTADO_LIMPANDO) || escrita_ok);
    assign mem_endereco = (estado == ESTADO_LIMPANDO) ? contador : endereco_escrita;
    assign mem_dado     = (estado == ESTADO_LIMPANDO) ? '0 : dado_escrita;

    memoria_2r1w #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_memoria (
        .clk              (clk),
        .escreve          (mem_escreve),
        .endereco_escrita (mem_endereco),
        .dado_escrita     (mem_dado),
        .endereco_a       (endereco_leitura_A),
        .endereco_b       (endereco_leitura_B),
        .dado_a           (mem_a),
        .dado_b           (mem_b)
    );

    // Write clears first, mark sets afterwards, so a simultaneous mark wins.
    always_comb begin
        pendentes_prox = pendentes;
        if (escrita_ok) begin
            pendentes_prox[endereco_escrita] = 1'b0;
        end
        if (marca_ok) begin
            pendentes_prox[endereco_pendente] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado      <= ESTADO_LIMPANDO;
            contador    <= '0;
            pendentes   <= '0;
            pronto      <= 1'b0;
            saida_ok    <= 1'b0;
            zero_a      <= 1'b0;
            zero_b      <= 1'b0;
            acerto_a    <= 1'b0;
            acerto_b    <= 1'b0;
            dado_bypass <= '0;
            pend_a      <= 1'b0;
            pend_b      <= 1'b0;
        end else begin
            case (estado)
                ESTADO_LIMPANDO: begin
                    contador <= contador + 1'b1;
                    if (contador == ULTIMO) begin
                        estado <= ESTADO_PRONTO;
                        pronto <= 1'b1;
                    end
                end
                default: begin
                    if (limpar) begin
                        estado    <= ESTADO_LIMPANDO;
                        contador  <= '0;
                        pendentes <= '0;
                        pronto    <= 1'b0;
                    end else begin
                        pendentes <= pendentes_prox;
                    end
                end
            endcase

            saida_ok    <= usuario_ativo;
            zero_a      <= eh_zero(endereco_leitura_A);
            zero_b      <= eh_zero(endereco_leitura_B);
            acerto_a    <= (BYPASS != 0) && escrita_ok && (endereco_escrita == endereco_leitura_A);
            acerto_b    <= (BYPASS != 0) && escrita_ok && (endereco_escrita == endereco_leitura_B);
            dado_bypass <= dado_escrita;
            pend_a      <= (BYPASS != 0) ? pendentes_prox[endereco_leitura_A] : pendentes[endereco_leitura_A];
            pend_b      <= (BYPASS != 0) ? pendentes_prox[endereco_leitura_B] : pendentes[endereco_leitura_B];
        end
    end

    assign dado_leitura_A = (!saida_ok || zero_a) ? '0 : (acerto_a ? dado_bypass : mem_a);
    assign dado_leitura_B = (!saida_ok || zero_b) ? '0 : (acerto_b ? dado_bypass : mem_b);
    assign pendente_A     = saida_ok && !zero_a && pend_a;
    assign pendente_B     = saida_ok && !zero_b && pend_b;

endmodule

// File: tb/tb_banco_registradores_param.sv
// Drives two bank configurations (bypass/no zero-R0 and no-bypass/zero-R0) with shared stimulus.
// Expected values come from directed constants and an array-based behavioural model.
module tb_banco_registradores_param;

    logic       clk = 1'b0;
    logic       reset, limpar, we, mk;
    logic [1:0] wa, pa, ra, rb;
    logic [7:0] wd;

    logic       pr_o [2];
    logic [7:0] da   [2];
    logic [7:0] db   [2];
    logic       pa_o [2];
    logic       pb_o [2];

    int n_cmp = 0;
    int n_err = 0;

    // Model state, index 0: BYPASS=1 ZERO_R0=0, index 1: BYPASS=0 ZERO_R0=1
    logic [7:0] m_mem  [2][4];
    logic       m_pend [2][4];
    bit         m_rdy  [2];
    int         m_cnt  [2];
    logic [7:0] e_da   [2];
    logic [7:0] e_db   [2];
    logic       e_pa   [2];
    logic       e_pb   [2];

    always #5 clk = ~clk;

    banco_registradores_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .BYPASS(1), .ZERO_R0(0)) u_byp (
        .clk(clk), .reset(reset), .limpar(limpar), .pronto(pr_o[0]),
        .habilita_escrita(we), .endereco_escrita(wa), .dado_escrita(wd),
        .marca_pendente(mk), .endereco_pendente(pa),
        .endereco_leitura_A(ra), .endereco_leitura_B(rb),
        .dado_leitura_A(da[0]), .dado_leitura_B(db[0]),
        .pendente_A(pa_o[0]), .pendente_B(pb_o[0])
    );

    banco_registradores_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .BYPASS(0), .ZERO_R0(1)) u_zr (
        .clk(clk), .reset(reset), .limpar(limpar), .pronto(pr_o[1]),
        .habilita_escrita(we), .endereco_escrita(wa), .dado_escrita(wd),
        .marca_pendente(mk), .endereco_pendente(pa),
        .endereco_leitura_A(ra), .endereco_leitura_B(rb),
        .dado_leitura_A(da[1]), .dado_leitura_B(db[1]),
        .pendente_A(pa_o[1]), .pendente_B(pb_o[1])
    );

    task automatic model_step();
        logic [7:0] om [4];
        logic       op [4];
        for (int c = 0; c < 2; c++) begin
            bit byp;
            bit zr;
            byp = (c == 0);
            zr  = (c == 1);
            e_da[c] = 8'h00; e_db[c] = 8'h00; e_pa[c] = 1'b0; e_pb[c] = 1'b0;
            if (reset) begin
                m_rdy[c] = 0; m_cnt[c] = 0;
                for (int i = 0; i < 4; i++) m_pend[c][i] = 1'b0;
            end else if (!m_rdy[c]) begin
                m_mem[c][m_cnt[c]] = 8'h00;
                m_cnt[c]++;
                if (m_cnt[c] == 4) m_rdy[c] = 1;
            end else if (limpar) begin
                m_rdy[c] = 0; m_cnt[c] = 0;
                for (int i = 0; i < 4; i++) m_pend[c][i] = 1'b0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    om[i] = m_mem[c][i];
                    op[i] = m_pend[c][i];
                end
                if (we && !(zr && wa == 2'd0)) begin
                    m_mem[c][wa]  = wd;
                    m_pend[c][wa] = 1'b0;
                end
                if (mk && !(zr && pa == 2'd0)) m_pend[c][pa] = 1'b1;
                if (!(zr && ra == 2'd0)) begin
                    e_da[c] = byp ? m_mem[c][ra]  : om[ra];
                    e_pa[c] = byp ? m_pend[c][ra] : op[ra];
                end
                if (!(zr && rb == 2'd0)) begin
                    e_db[c] = byp ? m_mem[c][rb]  : om[rb];
                    e_pb[c] = byp ? m_pend[c][rb] : op[rb];
                end
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; limpar = 0; we = 0; mk = 0;
        wa = 0; pa = 0; wd = 0;
    endtask

    task automatic test_reset();
        idle();
        ra = 0; rb = 0;
        reset = 1;
        step();
        reset = 0;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (pr_o[d] !== 1'b0 || da[d] !== 8'h00 || pa_o[d] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_state dut%0d: pronto=%b dado=%h pend=%b required 0/00/0", d, pr_o[d], da[d], pa_o[d]);
            end
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (pr_o[d] !== (k == 4)) begin
                    n_err++;
                    $display("FAIL sweep_pronto edge%0d dut%0d: got %b required %b", k, d, pr_o[d], (k == 4));
                end
            end
        end
        for (int r = 0; r < 4; r++) begin
            ra = 2'(r); rb = 2'(3 - r);
            step();
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (da[d] !== 8'h00 || db[d] !== 8'h00 || pa_o[d] !== 1'b0 || pb_o[d] !== 1'b0) begin
                    n_err++;
                    $display("FAIL clear_read r%0d dut%0d: got %h/%h %b/%b required 00/00 0/0", r, d, da[d], db[d], pa_o[d], pb_o[d]);
                end
            end
        end
    endtask

    task automatic test_write_read();
        idle();
        we = 1; wa = 2; wd = 8'hA5; ra = 0; rb = 0;
        step();
        we = 0; ra = 2; rb = 2;
        step();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (da[d] !== 8'hA5 || db[d] !== 8'hA5) begin
                n_err++;
                $display("FAIL write_read dut%0d: got %h/%h required a5/a5", d, da[d], db[d]);
            end
        end
    endtask

    task automatic test_bypass();
        idle();
        we = 1; wa = 1; wd = 8'h3C; ra = 1; rb = 1;
        step();
        n_cmp++;
        if (da[0] !== 8'h3C || db[0] !== 8'h3C) begin
            n_err++;
            $display("FAIL bypass_hit dut0: got %h/%h required 3c/3c", da[0], db[0]);
        end
        n_cmp++;
        if (da[1] !== 8'h00 || db[1] !== 8'h00) begin
            n_err++;
            $display("FAIL no_bypass_old dut1: got %h/%h required 00/00", da[1], db[1]);
        end
        we = 0;
        step();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (da[d] !== 8'h3C || db[d] !== 8'h3C) begin
                n_err++;
                $display("FAIL bypass_after dut%0d: got %h/%h required 3c/3c", d, da[d], db[d]);
            end
        end
    endtask

    task automatic test_zero_r0();
        idle();
        we = 1; wa = 0; wd = 8'hFF; mk = 1; pa = 0; ra = 0; rb = 3;
        step();
        we = 0; mk = 0;
        step();
        n_cmp++;
        if (da[0] !== 8'hFF || pa_o[0] !== 1'b1) begin
            n_err++;
            $display("FAIL r0_writable dut0: got %h pend %b required ff pend 1", da[0], pa_o[0]);
        end
        n_cmp++;
        if (da[1] !== 8'h00 || pa_o[1] !== 1'b0) begin
            n_err++;
            $display("FAIL r0_zero dut1: got %h pend %b required 00 pend 0", da[1], pa_o[1]);
        end
    endtask

    task automatic test_pending();
        logic [1:0] req0 [5];
        logic [1:0] req1 [5];
        // Per phase: {mark, write} with required pendente_A for dut0 and dut1.
        bit ph_mk [5] = '{1, 0, 1, 0, 1'b0};
        bit ph_we [5] = '{0, 0, 1, 1, 1'b0};
        req0 = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
        req1 = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
        idle();
        ra = 3; rb = 3; pa = 3; wa = 3;
        for (int p = 0; p < 5; p++) begin
            mk = ph_mk[p]; we = ph_we[p];
            wd = (p == 2) ? 8'h11 : 8'h22;
            step();
            n_cmp++;
            if (pa_o[0] !== req0[p][0] || pa_o[1] !== req1[p][0]) begin
                n_err++;
                $display("FAIL pending phase%0d: got %b/%b required %b/%b", p, pa_o[0], pa_o[1], req0[p][0], req1[p][0]);
            end
        end
        idle();
    endtask

    task automatic test_clear();
        idle();
        we = 1; wa = 1; wd = 8'h77; ra = 1; rb = 1;
        step();
        we = 0; limpar = 1;
        step();
        limpar = 0;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (pr_o[d] !== 1'b0) begin
                n_err++;
                $display("FAIL clear_start dut%0d: pronto got %b required 0", d, pr_o[d]);
            end
        end
        for (int k = 1; k <= 4; k++) begin
            we = (k == 1); wa = 1; wd = 8'h55; limpar = (k == 2);
            step();
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (pr_o[d] !== (k == 4) || da[d] !== 8'h00) begin
                    n_err++;
                    $display("FAIL clear_sweep edge%0d dut%0d: pronto %b dado %h required %b 00", k, d, pr_o[d], da[d], (k == 4));
                end
            end
        end
        idle();
        step();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (da[d] !== 8'h00) begin
                n_err++;
                $display("FAIL clear_result dut%0d: r1 got %h required 00", d, da[d]);
            end
        end
        limpar = 1;
        step();
        limpar = 0;
        step();
        reset = 1;
        step();
        reset = 0;
        for (int k = 1; k <= 4; k++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (pr_o[d] !== (k == 4)) begin
                    n_err++;
                    $display("FAIL midsweep_reset edge%0d dut%0d: got %b required %b", k, d, pr_o[d], (k == 4));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            reset  = ($urandom_range(99) == 0);
            limpar = ($urandom_range(39) == 0);
            we     = $urandom_range(1);
            mk     = ($urandom_range(2) == 0);
            wa     = 2'($urandom_range(3));
            pa     = 2'($urandom_range(3));
            ra     = 2'($urandom_range(3));
            rb     = 2'($urandom_range(3));
            wd     = 8'($urandom);
            step();
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (pr_o[d] !== m_rdy[d] || da[d] !== e_da[d] || db[d] !== e_db[d] ||
                    pa_o[d] !== e_pa[d] || pb_o[d] !== e_pb[d]) begin
                    n_err++;
                    $display("FAIL random cyc%0d dut%0d: got p%b %h %h %b %b required p%b %h %h %b %b",
                             n, d, pr_o[d], da[d], db[d], pa_o[d], pb_o[d],
                             m_rdy[d], e_da[d], e_db[d], e_pa[d], e_pb[d]);
                end
            end
        end
        idle();
    endtask

    initial begin
        for (int c = 0; c < 2; c++) begin
            m_rdy[c] = 0; m_cnt[c] = 0;
            for (int i = 0; i < 4; i++) begin
                m_mem[c][i] = 8'h00; m_pend[c][i] = 1'b0;
            end
        end
        idle();
        ra = 0; rb = 0;
        #1;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_r0();
        test_pending();
        test_clear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
